// File: rtl/dat_tx_phy.sv
// SD write-direction DAT line serializer: start bit, data, per-line CRC16, end bit,
// then bus release and card-busy wait. Pauses the SD clock instead of underrunning.
module dat_tx_phy #(
  parameter int BLK_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [BLK_W-1:0] block_size_i,
  input  logic             mode_i,
  input  logic [31:0]      word_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  output logic [3:0]       card_out,
  output logic             card_oe_o,
  input  logic [3:0]       card_in,
  output logic             sd_clk_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CW = BLK_W - 2;
  localparam logic [CW-1:0] ONE_W = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SBIT, S_DATA, S_CRC, S_EBIT, S_REL, S_BUSYW
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_mode;
  logic [CW-1:0]   r_words_left;
  logic [31:0]     r_hold;
  logic            r_hold_valid;
  logic            r_last;
  logic [31:0]     r_shift;
  logic [4:0]      r_bitcnt;
  logic [15:0]     r_crc [4];
  logic [3:0]      r_crccnt;
  logic            r_relcnt;
  logic            r_done;
  logic            r_err;

  logic [CW-1:0]   w_count;
  logic            w_start_ok;
  logic            w_boundary;
  logic            w_more;
  logic            w_bypass;
  logic            w_stall;
  logic            w_reload;
  logic            w_wait_load;
  logic            w_take_hold;
  logic            w_accept;
  logic [3:0]      w_line_bits;
  logic [4:0]      w_bits_per_word;
  logic [3:0]      w_out;
  logic            w_oe;
  logic            w_unused;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign w_count         = block_size_i[BLK_W-1:2];
  assign w_start_ok      = start_i && (w_count != '0);
  assign w_boundary      = (r_state == S_DATA) && (r_bitcnt == 5'd0);
  assign w_more          = (r_words_left != '0);
  // A word arriving exactly at an empty-hold boundary goes straight into the shifter
  assign w_bypass        = w_boundary && w_more && !r_hold_valid && word_valid_i;
  assign w_stall         = w_boundary && w_more && !r_hold_valid && !word_valid_i;
  assign w_reload        = w_boundary && w_more && !w_stall;
  assign w_wait_load     = (r_state == S_WAIT) && r_hold_valid;
  assign w_take_hold     = w_wait_load || (w_reload && r_hold_valid);
  assign w_accept        = word_valid_i && word_ready_o && !w_bypass;
  assign w_line_bits     = r_mode ? r_shift[31:28] : {3'b000, r_shift[31]};
  assign w_bits_per_word = r_mode ? 5'd7 : 5'd31;
  assign w_unused        = ^{card_in[3:1], block_size_i[1:0]};

  assign word_ready_o = !r_hold_valid && !(r_last && (r_state != S_IDLE));
  assign card_out     = w_out;
  assign card_oe_o    = w_oe;
  assign sd_clk_en_o  = !w_stall;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign err_o        = r_err;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_out  = 4'hF;
    w_oe   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_WAIT;
      S_WAIT: begin
        w_oe = 1'b1;
        if (r_hold_valid) w_next = S_SBIT;
      end
      S_SBIT: begin
        w_oe   = 1'b1;
        w_out  = r_mode ? 4'h0 : 4'hE;
        w_next = S_DATA;
      end
      S_DATA: begin
        w_oe  = 1'b1;
        w_out = r_mode ? r_shift[31:28] : {3'b111, r_shift[31]};
        if (w_boundary && !w_more) w_next = S_CRC;
      end
      S_CRC: begin
        w_oe  = 1'b1;
        w_out = r_mode ? {r_crc[3][15], r_crc[2][15], r_crc[1][15], r_crc[0][15]}
                       : {3'b111, r_crc[0][15]};
        if (r_crccnt == 4'd15) w_next = S_EBIT;
      end
      S_EBIT: begin
        w_oe   = 1'b1;
        w_next = S_REL;
      end
      S_REL:   if (r_relcnt) w_next = S_BUSYW;
      S_BUSYW: if (card_in[0]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: holding register, shifter, word/bit counters and per-line CRCs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mode       <= 1'b0;
      r_words_left <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_last       <= 1'b0;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_crccnt     <= '0;
      r_relcnt     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < 4; i++) r_crc[i] <= '0;
    end else begin
      r_done <= (r_state == S_BUSYW) && card_in[0];
      r_err  <= (r_state == S_IDLE) && start_i && (w_count == '0);

      if (w_take_hold) begin
        r_hold_valid <= 1'b0;
      end else if (w_accept) begin
        r_hold       <= word_i;
        r_hold_valid <= 1'b1;
      end

      if (r_state == S_IDLE)
        r_last <= 1'b0;
      else if ((w_wait_load || w_reload) && (r_words_left == ONE_W))
        r_last <= 1'b1;

      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_mode       <= mode_i;
          r_words_left <= w_count;
          for (int i = 0; i < 4; i++) r_crc[i] <= '0;
        end
        S_WAIT: if (r_hold_valid) begin
          r_shift      <= r_hold;
          r_bitcnt     <= w_bits_per_word;
          r_words_left <= r_words_left - ONE_W;
        end
        S_DATA: if (!w_stall) begin
          for (int i = 0; i < 4; i++)
            if (i == 0 || r_mode) r_crc[i] <= crc_step(r_crc[i], w_line_bits[i]);
          if (w_reload) begin
            r_shift      <= r_hold_valid ? r_hold : word_i;
            r_bitcnt     <= w_bits_per_word;
            r_words_left <= r_words_left - ONE_W;
          end else begin
            r_shift  <= r_mode ? {r_shift[27:0], 4'h0} : {r_shift[30:0], 1'b0};
            r_bitcnt <= r_bitcnt - 5'd1;
          end
        end
        S_CRC: begin
          for (int i = 0; i < 4; i++) r_crc[i] <= {r_crc[i][14:0], 1'b0};
          r_crccnt <= r_crccnt + 4'd1;
        end
        S_REL:   r_relcnt <= !r_relcnt;
        default: ;
      endcase
    end
  end

endmodule
